// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready memory port and
// hands each instruction to the datapath over a valid/ack port.
module fetch_unit #(
    parameter int COUNT_W = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [31:0]        startPC,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               instr_ack,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               br_taken,
    input  logic               jmp,
    input  logic               jr,
    input  logic [31:0]        rs_value,
    output logic               fault,
    output logic [COUNT_W-1:0] retired,
    output logic [1:0]         fsm_state
);

    // Handshakes: a memory word transfers on an edge where imem_req && imem_ready;
    // an instruction transfers on an edge where instr_valid && instr_ack. Neither
    // side's data may change while its valid/req is high and not yet accepted.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] br_offset;

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign fault       = (state == FAULT);
    assign fsm_state   = state;

    assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Control priority: jr > jmp > br_taken > fall-through.
    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = rs_value;
        else if (jmp)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (br_taken)
            next_pc = pc_plus4 + br_offset;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            pc      <= startPC;
            instr   <= 32'd0;
            retired <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= (pc[1:0] == 2'b00) ? FETCH : FAULT;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        retired <= retired + COUNT_W'(1);
                        pc      <= next_pc;
                        state   <= (next_pc[1:0] == 2'b00) ? FETCH : FAULT;
                    end
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule
